// File: rtl/play_sequencer.sv
// Audioport playback sequencer: command decode, STOPPED/PLAYING FSM, sample-tick
// generation, FIFO pop, status and IRQ. Define SEQ_UNDERRUN_STOP_EN to stop on underrun.
module play_sequencer #(
  parameter logic [31:0] CLK_DIV   = 32'd1042,
  parameter int          FIFO_SIZE = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid_in,
  input  logic [31:0]                    cmd_in,
  input  logic [$clog2(FIFO_SIZE+1)-1:0] fifo_level_in,
  input  logic                           fifo_empty_in,
  output logic                           fifo_rd_out,
  output logic                           tick_out,
  output logic                           clr_out,
  output logic                           cfg_out,
  output logic                           level_out,
  output logic                           play_out,
  output logic                           nodata_out,
  output logic                           irq_out,
  output logic                           cmd_err_out
);
  localparam int LW = $clog2(FIFO_SIZE+1);
  localparam logic [LW-1:0] HALF = LW'(FIFO_SIZE/2);

  typedef enum logic {STOPPED, PLAYING} state_t;
  state_t state_q, state_d;

  logic [31:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        under_q, under_d;
  logic        rd_d, tick_d, clr_d, cfg_d, level_d, play_d, nodata_d, irq_d, err_d;
  logic        bad, c_clr, c_cfg, c_start, c_stop, c_level, c_irqack;
  logic        stopped, playing, uflow_stop, irq_set;

  // A legal command is zero (NOP) or exactly one of the low six bits.
  assign bad      = cmd_valid_in && ((|cmd_in[31:6]) ||
                    (cmd_in[5:0] != 6'd0 && !$onehot(cmd_in[5:0])));
  assign c_clr    = cmd_valid_in && !bad && cmd_in[0];
  assign c_cfg    = cmd_valid_in && !bad && cmd_in[1];
  assign c_start  = cmd_valid_in && !bad && cmd_in[2];
  assign c_stop   = cmd_valid_in && !bad && cmd_in[3];
  assign c_level  = cmd_valid_in && !bad && cmd_in[4];
  assign c_irqack = cmd_valid_in && !bad && cmd_in[5];
  assign stopped  = (state_q == STOPPED);
  assign playing  = (state_q == PLAYING);

`ifdef SEQ_UNDERRUN_STOP_EN
  assign uflow_stop = playing && under_q;
`else
  assign uflow_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= STOPPED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: if (c_start) state_d = PLAYING;
      PLAYING: if (c_stop || uflow_stop) state_d = STOPPED;
      default: state_d = STOPPED;
    endcase
  end

  // Tick is registered, so it is launched in the cycle before the counter hits 0.
  always_comb begin
    cnt_d = cnt_q;
    if (stopped)                  cnt_d = c_start ? CLK_DIV - 32'd1 : 32'd0;
    else if (c_stop || uflow_stop) cnt_d = 32'd0;
    else if (cnt_q == 32'd0)       cnt_d = CLK_DIV - 32'd1;
    else                           cnt_d = cnt_q - 32'd1;

    tick_d  = playing && !c_stop && !uflow_stop && (cnt_q == 32'd1);
    rd_d    = tick_d && !fifo_empty_in;
    under_d = tick_d && fifo_empty_in;
    clr_d   = stopped && c_clr;
    cfg_d   = stopped && c_cfg;
    level_d = c_level;
    err_d   = bad || (playing && (c_clr || c_cfg));
    play_d  = (state_d == PLAYING);

`ifdef SEQ_UNDERRUN_STOP_EN
    irq_set = tick_d && armed_q && ((fifo_level_in <= HALF) || fifo_empty_in);
`else
    irq_set = tick_d && armed_q && (fifo_level_in <= HALF);
`endif

    nodata_d = nodata_out;
    if (stopped && (c_clr || c_start)) nodata_d = 1'b0;
    if (under_q)                       nodata_d = 1'b1;

    irq_d = irq_out;
    if (c_irqack || (stopped && c_clr) || (playing && c_stop)) irq_d = 1'b0;
    if (irq_set)                                               irq_d = 1'b1;

    armed_d = armed_q;
    if (fifo_level_in > HALF) armed_d = 1'b1;
    if (irq_set)              armed_d = 1'b0;
    if (stopped && c_start)   armed_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 32'd0;
      armed_q     <= 1'b0;
      under_q     <= 1'b0;
      fifo_rd_out <= 1'b0;
      tick_out    <= 1'b0;
      clr_out     <= 1'b0;
      cfg_out     <= 1'b0;
      level_out   <= 1'b0;
      play_out    <= 1'b0;
      nodata_out  <= 1'b0;
      irq_out     <= 1'b0;
      cmd_err_out <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      under_q     <= under_d;
      fifo_rd_out <= rd_d;
      tick_out    <= tick_d;
      clr_out     <= clr_d;
      cfg_out     <= cfg_d;
      level_out   <= level_d;
      play_out    <= play_d;
      nodata_out  <= nodata_d;
      irq_out     <= irq_d;
      cmd_err_out <= err_d;
    end
  end
endmodule

// File: tb/tb_play_sequencer.sv
// Directed bench for play_sequencer with CLK_DIV=8, FIFO_SIZE=16.
module tb_play_sequencer;
  localparam logic [31:0] CLK_DIV = 32'd8;
  localparam int FIFO_SIZE = 16;
  localparam logic [31:0] NOP = 0, CLR = 1, CFG = 2, START = 4, STOP = 8, LEVEL = 16, IRQACK = 32;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid_in = 1'b0;
  logic [31:0] cmd_in = '0;
  logic [4:0]  fifo_level_in = 5'd10;
  logic        fifo_empty_in = 1'b0;
  logic fifo_rd_out, tick_out, clr_out, cfg_out, level_out, play_out, nodata_out, irq_out, cmd_err_out;
  logic [8:0] outs;
  int errors = 0, checks = 0, cyc = 0;

  // {rd, tick, clr, cfg, level, play, nodata, irq, err}
  assign outs = {fifo_rd_out, tick_out, clr_out, cfg_out, level_out, play_out, nodata_out, irq_out, cmd_err_out};

  play_sequencer #(.CLK_DIV(CLK_DIV), .FIFO_SIZE(FIFO_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid_in(cmd_valid_in), .cmd_in(cmd_in),
    .fifo_level_in(fifo_level_in), .fifo_empty_in(fifo_empty_in),
    .fifo_rd_out(fifo_rd_out), .tick_out(tick_out), .clr_out(clr_out), .cfg_out(cfg_out),
    .level_out(level_out), .play_out(play_out), .nodata_out(nodata_out), .irq_out(irq_out),
    .cmd_err_out(cmd_err_out));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic send(input logic [31:0] c);
    cmd_valid_in = 1'b1; cmd_in = c;
    step();
    cmd_valid_in = 1'b0; cmd_in = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (outs !== 9'b0) begin errors++; $display("FAIL reset_state got=%b exp=%b", outs, 9'b0); end
    step(); rst_n = 1'b1; step();
    checks++;
    if (outs !== 9'b0) begin errors++; $display("FAIL idle_after_reset got=%b exp=%b", outs, 9'b0); end
  endtask

  task automatic test_tick();
    logic exp_t;
    fifo_level_in = 5'd10; fifo_empty_in = 1'b0;
    cyc = 0; send(START);
    checks++;
    if (play_out !== 1'b1) begin errors++; $display("FAIL tick_play_at_1 got=%b exp=1", play_out); end
    for (int c = 1; c <= 25; c++) begin
      run_to(c);
      exp_t = (c % 8 == 0);
      checks++;
      if ({tick_out, fifo_rd_out, cmd_err_out} !== {exp_t, exp_t, 1'b0}) begin
        errors++; $display("FAIL tick_cycle_%0d got=%b exp=%b", c, {tick_out, fifo_rd_out, cmd_err_out}, {exp_t, exp_t, 1'b0});
      end
    end
    send(STOP);
    checks++;
    if (play_out !== 1'b0) begin errors++; $display("FAIL tick_stop got=%b exp=0", play_out); end
  endtask

  task automatic test_illegal();
    send(32'h6);
    checks++;
    if (outs !== 9'b000000001) begin errors++; $display("FAIL illegal_6 got=%b exp=%b", outs, 9'b000000001); end
    send(32'h40);
    checks++;
    if (outs !== 9'b000000001) begin errors++; $display("FAIL illegal_40 got=%b exp=%b", outs, 9'b000000001); end
    send(CFG);
    checks++;
    if (outs !== 9'b000100000) begin errors++; $display("FAIL cfg_stopped got=%b exp=%b", outs, 9'b000100000); end
    step();
    checks++;
    if (cfg_out !== 1'b0) begin errors++; $display("FAIL cfg_one_cycle got=%b exp=0", cfg_out); end
    send(NOP);
    checks++;
    if (outs !== 9'b0) begin errors++; $display("FAIL nop got=%b exp=%b", outs, 9'b0); end
    send(START); send(LEVEL);
    checks++;
    if ({level_out, play_out, cmd_err_out} !== 3'b110) begin
      errors++; $display("FAIL level_playing got=%b exp=110", {level_out, play_out, cmd_err_out});
    end
    send(CFG);
    checks++;
    if ({cfg_out, cmd_err_out} !== 2'b01) begin errors++; $display("FAIL cfg_playing got=%b exp=01", {cfg_out, cmd_err_out}); end
    send(START);
    checks++;
    if ({play_out, cmd_err_out} !== 2'b10) begin errors++; $display("FAIL start_playing got=%b exp=10", {play_out, cmd_err_out}); end
    send(STOP);
    send(STOP);
    checks++;
    if ({play_out, cmd_err_out} !== 2'b00) begin errors++; $display("FAIL stop_stopped got=%b exp=00", {play_out, cmd_err_out}); end
  endtask

  task automatic test_irq();
    fifo_level_in = 5'd10; fifo_empty_in = 1'b0;
    cyc = 0; send(START);
    run_to(8);  fifo_level_in = 5'd9;
    run_to(16); fifo_level_in = 5'd8;
    run_to(23);
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_before_l8 got=%b exp=0", irq_out); end
    run_to(25);
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_after_l8 got=%b exp=1", irq_out); end
    fifo_level_in = 5'd7;
    send(IRQACK);
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_ack got=%b exp=0", irq_out); end
    run_to(41);
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_disarmed_l7 got=%b exp=0", irq_out); end
    fifo_level_in = 5'd9;
    run_to(48); fifo_level_in = 5'd8;
    run_to(55);
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_rearm_early got=%b exp=0", irq_out); end
    run_to(57);
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_rearm got=%b exp=1", irq_out); end
    fifo_level_in = 5'd10;
    send(STOP);
    checks++;
    if ({play_out, irq_out} !== 2'b00) begin errors++; $display("FAIL irq_stop_clear got=%b exp=00", {play_out, irq_out}); end
  endtask

`ifndef SEQ_UNDERRUN_STOP_EN
  task automatic test_underrun();
    fifo_level_in = 5'd0; fifo_empty_in = 1'b1;
    cyc = 0; send(START);
    run_to(8);
    checks++;
    if ({tick_out, fifo_rd_out, nodata_out} !== 3'b100) begin
      errors++; $display("FAIL underrun_tick got=%b exp=100", {tick_out, fifo_rd_out, nodata_out});
    end
    run_to(9);
    checks++;
    if ({nodata_out, play_out, irq_out} !== 3'b111) begin
      errors++; $display("FAIL underrun_nodata got=%b exp=111", {nodata_out, play_out, irq_out});
    end
    send(CLR);
    checks++;
    if ({clr_out, cmd_err_out, nodata_out} !== 3'b011) begin
      errors++; $display("FAIL clr_playing got=%b exp=011", {clr_out, cmd_err_out, nodata_out});
    end
    run_to(17);
    checks++;
    if ({play_out, nodata_out} !== 2'b11) begin errors++; $display("FAIL underrun_continues got=%b exp=11", {play_out, nodata_out}); end
    send(STOP);
    checks++;
    if ({play_out, nodata_out} !== 2'b01) begin errors++; $display("FAIL underrun_stop got=%b exp=01", {play_out, nodata_out}); end
    fifo_level_in = 5'd10; fifo_empty_in = 1'b0;
    send(CLR);
    checks++;
    if ({clr_out, nodata_out, irq_out, cmd_err_out} !== 4'b1000) begin
      errors++; $display("FAIL clr_stopped got=%b exp=1000", {clr_out, nodata_out, irq_out, cmd_err_out});
    end
  endtask
`else
  task automatic test_underrun_stop();
    logic seen;
    fifo_level_in = 5'd10; fifo_empty_in = 1'b0;
    cyc = 0; send(START);
    run_to(16); fifo_empty_in = 1'b1;
    run_to(24);
    checks++;
    if ({tick_out, fifo_rd_out} !== 2'b10) begin errors++; $display("FAIL ustop_tick3 got=%b exp=10", {tick_out, fifo_rd_out}); end
    run_to(25);
    checks++;
    if ({nodata_out, play_out, irq_out} !== 3'b101) begin
      errors++; $display("FAIL ustop_state got=%b exp=101", {nodata_out, play_out, irq_out});
    end
    seen = 1'b0;
    while (cyc < 45) begin step(); seen |= tick_out; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL ustop_no_tick4 got=%b exp=0", seen); end
    fifo_empty_in = 1'b0;
    send(CLR);
    checks++;
    if ({clr_out, nodata_out, irq_out} !== 3'b100) begin
      errors++; $display("FAIL ustop_clr got=%b exp=100", {clr_out, nodata_out, irq_out});
    end
  endtask
`endif

  task automatic test_reset_midplay();
    logic seen;
    fifo_level_in = 5'd10; fifo_empty_in = 1'b0;
    cyc = 0; send(START);
    run_to(20);
    checks++;
    if (play_out !== 1'b1) begin errors++; $display("FAIL midplay_playing got=%b exp=1", play_out); end
    rst_n = 1'b0; #1;
    checks++;
    if (outs !== 9'b0) begin errors++; $display("FAIL midplay_reset got=%b exp=%b", outs, 9'b0); end
    step(); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin step(); seen |= tick_out | play_out; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midplay_no_tick got=%b exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_illegal();
    test_irq();
`ifndef SEQ_UNDERRUN_STOP_EN
    test_underrun();
`else
    test_underrun_stop();
`endif
    test_reset_midplay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
